// File: rtl/genius_pkg.sv
// Shared constants for the Genius flash sequencer: colour codes, quadrant RGB
// values, FSM state encoding and the default quadrant split.
package genius_pkg;

  localparam logic [1:0] COL_GREEN  = 2'd0;
  localparam logic [1:0] COL_RED    = 2'd1;
  localparam logic [1:0] COL_YELLOW = 2'd2;
  localparam logic [1:0] COL_BLUE   = 2'd3;

  localparam logic [23:0] RGB_GREEN_FULL  = 24'h00FF00;
  localparam logic [23:0] RGB_RED_FULL    = 24'hFF0000;
  localparam logic [23:0] RGB_YELLOW_FULL = 24'hFFFF00;
  localparam logic [23:0] RGB_BLUE_FULL   = 24'h0000FF;

  localparam logic [23:0] RGB_GREEN_DIM  = 24'h004000;
  localparam logic [23:0] RGB_RED_DIM    = 24'h400000;
  localparam logic [23:0] RGB_YELLOW_DIM = 24'h404000;
  localparam logic [23:0] RGB_BLUE_DIM   = 24'h000040;

  localparam int unsigned G_HALF_DEFAULT = 180;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SYNC,
    ST_ON,
    ST_OFF,
    ST_FIN
  } state_t;

  function automatic logic [23:0] quad_rgb(input logic [1:0] code, input logic lit);
    logic [23:0] rgb;
    case (code)
      COL_GREEN:  rgb = lit ? RGB_GREEN_FULL  : RGB_GREEN_DIM;
      COL_RED:    rgb = lit ? RGB_RED_FULL    : RGB_RED_DIM;
      COL_YELLOW: rgb = lit ? RGB_YELLOW_FULL : RGB_YELLOW_DIM;
      default:    rgb = lit ? RGB_BLUE_FULL   : RGB_BLUE_DIM;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/genius_quadrant_painter.sv
// Decodes the pixel's quadrant inside the game area and registers the
// full or dim colour for it.
module genius_quadrant_painter
  import genius_pkg::*;
#(
  parameter int unsigned HALF = G_HALF_DEFAULT
) (
  input  logic        VGA_CLK,
  input  logic        RESET,
  input  logic        lit_en,
  input  logic [1:0]  lit_color,
  input  logic        DISP_EN,
  input  logic [8:0]  PIX_X,
  input  logic [8:0]  PIX_Y,
  output logic [23:0] RGB
);

  logic [1:0] quad;
  logic       lit;

  assign quad = {PIX_Y >= 9'(HALF), PIX_X >= 9'(HALF)};
  assign lit  = lit_en && (lit_color == quad);

  always_ff @(posedge VGA_CLK) begin
    if (RESET)         RGB <= '0;
    else if (!DISP_EN) RGB <= '0;
    else               RGB <= quad_rgb(quad, lit);
  end

endmodule

// File: rtl/genius_flash_sequencer.sv
// Plays a stored colour sequence on the four game quadrants, frame-locked to
// VGA_VS; mirrors the player's button while idle.
module genius_flash_sequencer
  import genius_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned ON_FRAMES  = 30,
  parameter int unsigned OFF_FRAMES = 15,
  parameter int unsigned G_HALF     = G_HALF_DEFAULT
) (
  input  logic              VGA_CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [5:0]        LEN,
  output logic [ADDR_W-1:0] SEQ_ADDR,
  input  logic [1:0]        SEQ_DATA,
  input  logic              PRESS_VALID,
  input  logic [1:0]        PRESS_COLOR,
  input  logic              VGA_VS,
  input  logic              DISP_EN,
  input  logic [8:0]        PIX_X,
  input  logic [8:0]        PIX_Y,
  output logic [23:0]       RGB,
  output logic              BUSY,
  output logic              LIT_VALID,
  output logic [1:0]        LIT_COLOR,
  output logic              DONE
);

  localparam int unsigned IW       = ADDR_W + 1;
  localparam logic [7:0]  ON_LAST  = 8'(ON_FRAMES - 1);
  localparam logic [7:0]  OFF_LAST = 8'(OFF_FRAMES - 1);

  state_t        state, state_nxt;
  logic          vs_q, tick;
  logic [IW-1:0] idx, idx_nxt, len_q, len_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [1:0]    color_q, color_nxt;
  logic          sync_first, sync_first_nxt;
  logic          lit_en;
  logic [1:0]    lit_sel;

  // Falling edge of active-low VS marks the start of a new frame.
  assign tick = vs_q & ~VGA_VS;

  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      vs_q       <= 1'b1;
      idx        <= '0;
      len_q      <= '0;
      cnt        <= '0;
      color_q    <= '0;
      sync_first <= 1'b0;
    end else begin
      state      <= state_nxt;
      vs_q       <= VGA_VS;
      idx        <= idx_nxt;
      len_q      <= len_nxt;
      cnt        <= cnt_nxt;
      color_q    <= color_nxt;
      sync_first <= sync_first_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    len_nxt        = len_q;
    cnt_nxt        = cnt;
    color_nxt      = color_q;
    sync_first_nxt = sync_first;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (LEN == 6'd0) begin
            state_nxt = ST_FIN;
          end else begin
            len_nxt   = (32'(LEN) > MAX_LEN) ? IW'(MAX_LEN) : IW'(LEN);
            idx_nxt   = '0;
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        sync_first_nxt = 1'b1;
        state_nxt      = ST_SYNC;
      end
      ST_SYNC: begin
        // RAM data lands on the entry cycle; ticks there are deliberately skipped.
        if (sync_first) begin
          color_nxt      = SEQ_DATA;
          sync_first_nxt = 1'b0;
        end else if (tick) begin
          cnt_nxt   = '0;
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (cnt == ON_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_OFF;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      ST_OFF: begin
        if (tick) begin
          if (cnt == OFF_LAST) begin
            cnt_nxt = '0;
            if (idx == len_q - IW'(1)) begin
              state_nxt = ST_FIN;
            end else begin
              idx_nxt   = idx + IW'(1);
              state_nxt = ST_FETCH;
            end
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign SEQ_ADDR  = idx[ADDR_W-1:0];
  assign BUSY      = (state != ST_IDLE);
  assign LIT_VALID = (state == ST_ON);
  assign LIT_COLOR = color_q;
  assign DONE      = (state == ST_FIN);

  assign lit_en  = LIT_VALID || ((state == ST_IDLE) && PRESS_VALID);
  assign lit_sel = LIT_VALID ? color_q : PRESS_COLOR;

  genius_quadrant_painter #(
    .HALF(G_HALF)
  ) u_painter (
    .VGA_CLK  (VGA_CLK),
    .RESET    (RESET),
    .lit_en   (lit_en),
    .lit_color(lit_sel),
    .DISP_EN  (DISP_EN),
    .PIX_X    (PIX_X),
    .PIX_Y    (PIX_Y),
    .RGB      (RGB)
  );

endmodule
